// File: rtl/cmd_bus_exec.sv
// -----------------------------------------------------------------------------
// cmd_bus_exec
//  Consumes the command FSM's cmd_type stream. Each new non-idle code is
//  encoded into a 2-bit bus operation and queued in a small FIFO. A single
//  executor drains the FIFO and runs each operation as a 4-phase req/ack
//  handshake, with a per-phase timeout.
//
// Ports
//  clk       in   1          clock, rising edge
//  nReset    in   1          asynchronous reset, active low
//  ena       in   1          capture enable (0 = nothing new is queued)
//  cmd_type  in   8          command code from the command FSM
//  err_clr   in   1          clears the sticky flags ovf/tout/unk
//  bus_ack   in   1          bus acknowledge
//  bus_req   out  1          bus request
//  bus_op    out  2          encoded operation, stable while bus_req=1
//  busy      out  1          executor active or FIFO not empty
//  done      out  1          one-cycle pulse per completed command
//  ovf       out  1          sticky: known command dropped, FIFO full
//  tout      out  1          sticky: handshake timeout
//  unk       out  1          sticky: unknown non-idle code seen
//  fifo_cnt  out  FIFO_AW+1  FIFO occupancy
// -----------------------------------------------------------------------------
module cmd_bus_exec #(
    parameter int          FIFO_AW     = 2,
    parameter logic [15:0] TIMEOUT     = 16'h00FF,
    parameter logic [7:0]  C_CMD_IDLE  = 8'h00,
    parameter logic [7:0]  C_CMD_START = 8'h80,
    parameter logic [7:0]  C_CMD_RD    = 8'h20,
    parameter logic [7:0]  C_CMD_WR    = 8'h40,
    parameter logic [7:0]  C_CMD_ACK   = 8'hFF
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic               ena,
    input  logic [7:0]         cmd_type,
    input  logic               err_clr,
    input  logic               bus_ack,
    output logic               bus_req,
    output logic [1:0]         bus_op,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic               tout,
    output logic               unk,
    output logic [FIFO_AW:0]   fifo_cnt
);

    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE  = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW:0]   CNT_ZERO = (FIFO_AW+1)'(0);
    localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW+1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;

    // Returns {known, op}; known=0 for any code outside the command table.
    function automatic logic [2:0] encode_cmd(input logic [7:0] code);
        logic [2:0] res;
        case (code)
            C_CMD_START: res = {1'b1, 2'b00};
            C_CMD_RD:    res = {1'b1, 2'b01};
            C_CMD_WR:    res = {1'b1, 2'b10};
            C_CMD_ACK:   res = {1'b1, 2'b11};
            default:     res = {1'b0, 2'b00};
        endcase
        return res;
    endfunction

    logic [7:0]         cmd_prev_q, cmd_prev_d;
    logic [1:0]         mem_q [DEPTH];
    logic [1:0]         mem_d [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic [1:0]         state_q, state_d;
    logic [15:0]        timer_q, timer_d;
    logic [1:0]         op_q, op_d;
    logic               req_q, req_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ovf_q, ovf_d;
    logic               tout_q, tout_d;
    logic               unk_q, unk_d;

    logic               new_s, known_s, full_s, push_s, pop_s;
    logic               ovf_set_s, unk_set_s, tout_set_s;
    logic [1:0]         enc_op_s;
    logic [15:0]        timer_inc_s;

    // Capture side: edge-detect new codes and decide push / drop / unknown.
    always_comb begin
        {known_s, enc_op_s} = encode_cmd(cmd_type);
        new_s      = ena && (cmd_type != cmd_prev_q) && (cmd_type != C_CMD_IDLE);
        // Full uses start-of-cycle occupancy: a same-cycle pop does not make room.
        full_s     = (cnt_q == CNT_FULL);
        push_s     = new_s && known_s && !full_s;
        ovf_set_s  = new_s && known_s && full_s;
        unk_set_s  = new_s && !known_s;
        cmd_prev_d = cmd_type;
    end

    // FIFO storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = enc_op_s;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Executor FSM: pop, request, wait ack high, wait ack low, pulse done.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        req_d       = req_q;
        done_d      = 1'b0;
        tout_set_s  = 1'b0;
        pop_s       = 1'b0;
        timer_inc_s = (timer_q == 16'hFFFF) ? timer_q : (timer_q + 16'd1);
        timer_d     = timer_q;
        case (state_q)
            S_IDLE: begin
                req_d   = 1'b0;
                timer_d = 16'd0;
                if (cnt_q != CNT_ZERO) begin
                    pop_s   = 1'b1;
                    op_d    = mem_q[rd_ptr_q];
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                // Request is raised during the first S_REQ cycle, so ack is
                // only honoured once it is actually on the bus.
                if (req_q && bus_ack) begin
                    req_d   = 1'b0;
                    timer_d = 16'd0;
                    state_d = S_REL;
                end else if (timer_q == TIMEOUT) begin
                    req_d      = 1'b0;
                    timer_d    = 16'd0;
                    tout_set_s = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    req_d   = 1'b1;
                    timer_d = timer_inc_s;
                end
            end
            S_REL: begin
                if (!bus_ack) begin
                    done_d  = 1'b1;
                    timer_d = 16'd0;
                    state_d = S_IDLE;
                end else if (timer_q == TIMEOUT) begin
                    tout_set_s = 1'b1;
                    timer_d    = 16'd0;
                    state_d    = S_IDLE;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            default: begin
                req_d   = 1'b0;
                timer_d = 16'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky flags (a set beats a clear) and registered busy.
    always_comb begin
        ovf_d  = ovf_set_s  || (ovf_q  && !err_clr);
        tout_d = tout_set_s || (tout_q && !err_clr);
        unk_d  = unk_set_s  || (unk_q  && !err_clr);
        busy_d = (state_d != S_IDLE) || (cnt_d != CNT_ZERO);
    end

    // State registers; reset drops bus_req at once and discards the queue.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            cmd_prev_q <= C_CMD_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 2'b00;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= CNT_ZERO;
            state_q  <= S_IDLE;
            timer_q  <= 16'd0;
            op_q     <= 2'b00;
            req_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            tout_q   <= 1'b0;
            unk_q    <= 1'b0;
        end else begin
            cmd_prev_q <= cmd_prev_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            op_q       <= op_d;
            req_q      <= req_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
            tout_q     <= tout_d;
            unk_q      <= unk_d;
        end
    end

    assign bus_req  = req_q;
    assign bus_op   = op_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign tout     = tout_q;
    assign unk      = unk_q;
    assign fifo_cnt = cnt_q;

endmodule

// File: tb/tb_cmd_bus_exec.sv
// -----------------------------------------------------------------------------
// tb_cmd_bus_exec
//  Directed bench for cmd_bus_exec. A background responder answers bus_req
//  after three cycles when auto_ack is set; done pulses are counted in the
//  background. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_cmd_bus_exec;

    localparam logic [15:0] TIMEOUT = 16'h00FF;

    logic       clk;
    logic       nReset;
    logic       ena;
    logic [7:0] cmd_type;
    logic       err_clr;
    logic       bus_ack;
    logic       bus_req;
    logic [1:0] bus_op;
    logic       busy;
    logic       done;
    logic       ovf;
    logic       tout;
    logic       unk;
    logic [2:0] fifo_cnt;

    int  n_tests  = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    int  d0;
    int  ack_dly  = 0;
    logic auto_ack = 1'b0;

    cmd_bus_exec #(.FIFO_AW(2), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .nReset   (nReset),
        .ena      (ena),
        .cmd_type (cmd_type),
        .err_clr  (err_clr),
        .bus_ack  (bus_ack),
        .bus_req  (bus_req),
        .bus_op   (bus_op),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .tout     (tout),
        .unk      (unk),
        .fifo_cnt (fifo_cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Bus responder: ack three cycles into a request, release when req drops.
    initial begin
        bus_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!auto_ack || !bus_req) begin
                bus_ack = 1'b0;
                ack_dly = 0;
            end else if (!bus_ack) begin
                ack_dly++;
                if (ack_dly >= 3) bus_ack = 1'b1;
            end
        end
    end

    // Count done pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    end

    // Run-away guard.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for bus_req to reach lvl, then compare it.
    task automatic wait_req(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (bus_req !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, bus_req}, {31'd0, lvl});
    endtask

    task automatic send(input logic [7:0] c);
        cmd_type = c;
        @(negedge clk);
    endtask

    task automatic do_reset();
        nReset   = 1'b0;
        cmd_type = 8'h00;
        ena      = 1'b1;
        err_clr  = 1'b0;
        auto_ack = 1'b0;
        repeat (2) @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);
    endtask

    logic [1:0] exp_ops [5];

    initial begin
        nReset   = 1'b0;
        ena      = 1'b1;
        cmd_type = 8'h00;
        err_clr  = 1'b0;
        #1;
        chk("reset_outputs", {22'd0, bus_req, bus_op, busy, done, ovf, tout, unk, fifo_cnt}, 32'd0);
        do_reset();

        // 1: single START, latency and one done pulse.
        auto_ack = 1'b1;
        d0 = done_cnt;
        cmd_type = 8'h80;
        @(negedge clk);                       // after push edge N
        chk("t1_cnt_after_push", {29'd0, fifo_cnt}, 32'd1);
        @(negedge clk);                       // after pop edge N+1
        chk("t1_req_not_yet", {31'd0, bus_req}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_cnt_after_pop", {29'd0, fifo_cnt}, 32'd0);
        @(negedge clk);                       // after edge N+2
        chk("t1_req_high", {31'd0, bus_req}, 32'd1);
        chk("t1_op", {30'd0, bus_op}, 32'd0);
        wait_req(1'b0, 20, "t1_req_fall");
        repeat (5) @(negedge clk);
        chk("t1_done_pulses", done_cnt - d0, 32'd1);
        chk("t1_cnt_end", {29'd0, fifo_cnt}, 32'd0);
        chk("t1_busy_end", {31'd0, busy}, 32'd0);
        cmd_type = 8'h00;
        @(negedge clk);

        // 2: executor held on RD while 80,20,40,FF queue up, then drained in order.
        auto_ack = 1'b0;
        d0 = done_cnt;
        send(8'h20);
        send(8'h80);
        send(8'h20);
        send(8'h40);
        send(8'hFF);
        cmd_type = 8'h00;
        chk("t2_cnt_full", {29'd0, fifo_cnt}, 32'd4);
        chk("t2_req_stalled", {31'd0, bus_req}, 32'd1);
        exp_ops[0] = 2'b01;
        exp_ops[1] = 2'b00;
        exp_ops[2] = 2'b01;
        exp_ops[3] = 2'b10;
        exp_ops[4] = 2'b11;
        auto_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_req(1'b1, 20, $sformatf("t2_req_rise%0d", i));
            chk($sformatf("t2_op%0d", i), {30'd0, bus_op}, {30'd0, exp_ops[i]});
            wait_req(1'b0, 20, $sformatf("t2_req_fall%0d", i));
        end
        repeat (5) @(negedge clk);
        chk("t2_done_pulses", done_cnt - d0, 32'd5);
        chk("t2_cnt_end", {29'd0, fifo_cnt}, 32'd0);

        // 3: overflow when full; err_clr; set beats clear.
        do_reset();
        send(8'h80);
        send(8'h20);
        send(8'h40);
        send(8'hFF);
        send(8'h80);
        chk("t3_cnt_full", {29'd0, fifo_cnt}, 32'd4);
        chk("t3_no_ovf_yet", {31'd0, ovf}, 32'd0);
        send(8'h20);
        chk("t3_ovf_set", {31'd0, ovf}, 32'd1);
        chk("t3_cnt_unchanged", {29'd0, fifo_cnt}, 32'd4);
        cmd_type = 8'h00;
        err_clr  = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t3_ovf_cleared", {31'd0, ovf}, 32'd0);
        cmd_type = 8'h40;
        err_clr  = 1'b1;
        @(negedge clk);
        err_clr  = 1'b0;
        cmd_type = 8'h00;
        chk("t3_set_beats_clear", {31'd0, ovf}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t3_ovf_cleared2", {31'd0, ovf}, 32'd0);

        // 4: no ack -> timeout, then the next entry is popped.
        do_reset();
        d0 = done_cnt;
        send(8'h80);
        send(8'h40);
        cmd_type = 8'h00;
        wait_req(1'b1, 5, "t4_req_rise");
        begin
            int n = 0;
            while (bus_req && n < 400) begin
                @(negedge clk);
                n++;
            end
            // Request is raised one cycle after the pop, so TIMEOUT cycles
            // high means the fall lands TIMEOUT+1 cycles after the pop.
            chk("t4_req_high_cycles", n, {16'd0, TIMEOUT});
        end
        chk("t4_tout", {31'd0, tout}, 32'd1);
        chk("t4_no_done", done_cnt - d0, 32'd0);
        wait_req(1'b1, 5, "t4_next_req");
        chk("t4_next_op", {30'd0, bus_op}, 32'd2);
        auto_ack = 1'b1;
        wait_req(1'b0, 20, "t4_next_fall");
        repeat (4) @(negedge clk);
        chk("t4_next_done", done_cnt - d0, 32'd1);
        chk("t4_tout_sticky", {31'd0, tout}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_tout_cleared", {31'd0, tout}, 32'd0);

        // 5: unknown code, held code, and ena=0.
        do_reset();
        auto_ack = 1'b1;
        d0 = done_cnt;
        cmd_type = 8'h33;
        @(negedge clk);
        chk("t5_unk", {31'd0, unk}, 32'd1);
        chk("t5_unk_not_queued", {29'd0, fifo_cnt}, 32'd0);
        chk("t5_unk_not_busy", {31'd0, busy}, 32'd0);
        cmd_type = 8'h20;
        repeat (10) @(negedge clk);
        cmd_type = 8'h00;
        repeat (20) @(negedge clk);
        chk("t5_held_one_push", done_cnt - d0, 32'd1);
        ena = 1'b0;
        cmd_type = 8'h40;
        repeat (3) @(negedge clk);
        ena = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_ena_cnt", {29'd0, fifo_cnt}, 32'd0);
        chk("t5_ena_busy", {31'd0, busy}, 32'd0);
        chk("t5_ena_no_done", done_cnt - d0, 32'd1);
        cmd_type = 8'h00;

        // 6: reset mid-handshake with two entries queued.
        do_reset();
        send(8'h80);
        send(8'h20);
        send(8'h40);
        cmd_type = 8'h00;
        chk("t6_req_before", {31'd0, bus_req}, 32'd1);
        chk("t6_cnt_before", {29'd0, fifo_cnt}, 32'd2);
        #2;
        nReset = 1'b0;
        #1;
        chk("t6_outs_async", {22'd0, bus_req, bus_op, busy, done, ovf, tout, unk, fifo_cnt}, 32'd0);
        @(negedge clk);
        nReset = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_cnt_after", {29'd0, fifo_cnt}, 32'd0);
        chk("t6_busy_after", {31'd0, busy}, 32'd0);
        chk("t6_req_after", {31'd0, bus_req}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
